serial_subtractor: RTL

Bit-serial unsigned/signed subtractor. It computes `a - b` one bit per cycle, LSB first, using a single full-subtractor cell and a registered borrow. It sits in the ALU beside the combinational adder chain and serves as the area-minimal subtract/compare path. A start/busy/done handshake connects it to the ALU control sequencer.

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first, through a
// single full-subtractor cell, with start/busy/done handshake and held flags.
module serial_subtractor #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             d_bit;
    logic             bw_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sa_q       <= '0;
            sb_q       <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            bw_q       <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            bw_q       <= bw_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    // Next-state, full-subtractor cell and result capture
    always_comb begin
        state_d    = state_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        bw_d       = bw_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        d_bit      = sa_q[0] ^ sb_q[0] ^ bw_q;
        bw_next    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                bw_d  = bw_next;
                // Last bit: publish the completed result together with the flags
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = DONE;
                    diff_d     = res_d;
                    borrow_d   = bw_next;
                    overflow_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
                    zero_d     = (res_d == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
